// File: rtl/tia_pkg.sv
// Shared constants, register map and colour-priority helpers for the
// video-only TIA model.
package tia_pkg;

    // Line timing defaults (colour clocks).
    localparam logic [7:0] LINE_CLKS_DEF   = 8'd228;
    localparam logic [7:0] HBLANK_CLKS_DEF = 8'd68;
    localparam logic [7:0] HSYNC_START_DEF = 8'd16;
    localparam logic [7:0] HSYNC_END_DEF   = 8'd31;

    // Visible line geometry.
    localparam logic [7:0] VIS_CLKS  = 8'd160;
    localparam logic [7:0] HALF_CLKS = 8'd80;
    localparam int         PF_BITS   = 20;

    // Register addresses.
    localparam logic [5:0] A_VSYNC  = 6'h00;
    localparam logic [5:0] A_VBLANK = 6'h01;
    localparam logic [5:0] A_WSYNC  = 6'h02;
    localparam logic [5:0] A_RSYNC  = 6'h03;
    localparam logic [5:0] A_COLUP0 = 6'h06;
    localparam logic [5:0] A_COLUP1 = 6'h07;
    localparam logic [5:0] A_COLUPF = 6'h08;
    localparam logic [5:0] A_COLUBK = 6'h09;
    localparam logic [5:0] A_CTRLPF = 6'h0A;
    localparam logic [5:0] A_REFP0  = 6'h0B;
    localparam logic [5:0] A_REFP1  = 6'h0C;
    localparam logic [5:0] A_PF0    = 6'h0D;
    localparam logic [5:0] A_PF1    = 6'h0E;
    localparam logic [5:0] A_PF2    = 6'h0F;
    localparam logic [5:0] A_RESP0  = 6'h10;
    localparam logic [5:0] A_RESP1  = 6'h11;
    localparam logic [5:0] A_GRP0   = 6'h1B;
    localparam logic [5:0] A_GRP1   = 6'h1C;

    // Which colour register drives the current pixel.
    typedef enum logic [1:0] {
        SRC_BK = 2'd0,
        SRC_PF = 2'd1,
        SRC_P0 = 2'd2,
        SRC_P1 = 2'd3
    } col_src_e;

    // Normal order is P0 > P1 > PF > BK; pf_pri lifts PF above both players.
    function automatic col_src_e pick_src(input logic pf_pri, input logic pf,
                                          input logic p0, input logic p1);
        col_src_e s;
        s = SRC_BK;
        if (pf_pri) begin
            if (pf)      s = SRC_PF;
            else if (p0) s = SRC_P0;
            else if (p1) s = SRC_P1;
        end else begin
            if (p0)      s = SRC_P0;
            else if (p1) s = SRC_P1;
            else if (pf) s = SRC_PF;
        end
        return s;
    endfunction

    // PF1 is shifted out MSB first, so it is stored reversed in the PF vector.
    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[k] = v[7-k];
        return r;
    endfunction

    // Playfield bit for a 0..19 index; anything out of range reads as empty.
    function automatic logic pf_lookup(input logic [PF_BITS-1:0] bits,
                                       input logic [7:0] idx);
        logic r;
        r = 1'b0;
        for (int k = 0; k < PF_BITS; k++) begin
            if (idx == 8'(k)) r = bits[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/tia_player.sv
// One single-copy 8-pixel player: position, graphics and reflect registers,
// plus the pixel decode for the current beam position.
module tia_player
    import tia_pkg::*;
#(
    parameter logic [5:0] RES_ADDR = A_RESP0,
    parameter logic [5:0] GRP_ADDR = A_GRP0,
    parameter logic [5:0] REF_ADDR = A_REFP0,
    parameter logic [7:0] HBLANK   = HBLANK_CLKS_DEF
) (
    input  logic       osc,
    input  logic       reset,
    input  logic       we_i,
    input  logic [5:0] a_i,
    input  logic [7:0] d_i,
    input  logic [7:0] hcount_i,
    output logic       pix_o
);

    logic [7:0] pos_q, pos_d;
    logic [7:0] grp_q, grp_d;
    logic       ref_q, ref_d;
    logic [7:0] x;
    logic [8:0] off;

    // Beam x; wraps to a large value during hblank, where output is blanked.
    assign x = hcount_i - HBLANK;

    // Register writes and the RES strobe (position snaps to 0 in hblank).
    always_comb begin
        pos_d = pos_q;
        grp_d = grp_q;
        ref_d = ref_q;
        if (we_i) begin
            if (a_i == RES_ADDR) pos_d = (hcount_i >= HBLANK) ? x : 8'd0;
            if (a_i == GRP_ADDR) grp_d = d_i;
            if (a_i == REF_ADDR) ref_d = d_i[3];
        end
    end

    // Player state registers.
    always_ff @(posedge osc or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
            grp_q <= '0;
            ref_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            grp_q <= grp_d;
            ref_q <= ref_d;
        end
    end

    // Offset from the player start modulo the visible width, so a player
    // placed near the right edge wraps onto the left edge.
    always_comb begin
        if (x >= pos_q) off = {1'b0, x} - {1'b0, pos_q};
        else            off = {1'b0, x} + {1'b0, VIS_CLKS} - {1'b0, pos_q};
        pix_o = 1'b0;
        if (off < 9'd8) pix_o = ref_q ? grp_q[off[2:0]] : grp_q[3'd7 - off[2:0]];
    end

endmodule

// File: rtl/tia_no_audio.sv
// Video-only TIA: colour-clock line timing, CPU clock divider, WSYNC halt,
// background/playfield/two players and registered blank/sync/luma/chroma.
module tia_no_audio
    import tia_pkg::*;
#(
    parameter logic [7:0] LINE_CLKS   = LINE_CLKS_DEF,
    parameter logic [7:0] HBLANK_CLKS = HBLANK_CLKS_DEF,
    parameter logic [7:0] HSYNC_START = HSYNC_START_DEF,
    parameter logic [7:0] HSYNC_END   = HSYNC_END_DEF
) (
    input  logic       osc,
    input  logic       reset,
    input  logic [7:0] d,
    input  logic [5:0] a,
    input  logic       phi2,
    output logic       blk_bar,
    output logic [2:0] l,
    output logic [3:0] c,
    output logic       syn,
    output logic       rdy,
    output logic       phi_theta
);

    logic [1:0] div_q, div_d;
    logic       phi_q, phi_d;
    logic [7:0] hcount_q, hcount_d;
    logic       rdy_q, rdy_d;
    logic       we;

    logic       vsync_q, vsync_d, vblank_q, vblank_d;
    logic [7:1] colup0_q, colup0_d, colup1_q, colup1_d;
    logic [7:1] colupf_q, colupf_d, colubk_q, colubk_d;
    logic [2:0] ctrlpf_q, ctrlpf_d;
    logic [3:0] pf0_q, pf0_d;
    logic [7:0] pf1_q, pf1_d, pf2_q, pf2_d;

    logic       blk_q, blk_d, syn_q, syn_d;
    logic [2:0] l_q, l_d;
    logic [3:0] c_q, c_d;

    logic [7:0]         x, half_x, pf_idx;
    logic               left, pf_on, p0_on, p1_on, blank;
    logic [PF_BITS-1:0] pf_bits;
    logic [7:1]         pf_col, col;
    col_src_e           src;

    // A write lands on the last colour clock of a CPU cycle.
    assign we = (div_q == 2'd2) && phi2;

    // CPU clock: div cycles 0,1,2 and phi_theta is high the clock after div==0.
    always_comb begin
        div_d = (div_q == 2'd2) ? 2'd0 : div_q + 2'd1;
        phi_d = (div_q == 2'd0);
    end

    // Line counter with RSYNC restart; rdy drops on WSYNC and returns when the
    // counter comes back to 0. WSYNC wins so a strobe on the wrap edge halts
    // the CPU through the whole next line.
    always_comb begin
        hcount_d = (hcount_q == LINE_CLKS - 8'd1) ? 8'd0 : hcount_q + 8'd1;
        if (we && a == A_RSYNC) hcount_d = 8'd0;
        rdy_d = rdy_q;
        if (we && a == A_WSYNC)  rdy_d = 1'b0;
        else if (hcount_d == 8'd0) rdy_d = 1'b1;
    end

    // Register file writes; colour bit 0 is never displayed so it is not kept.
    always_comb begin
        vsync_d  = vsync_q;
        vblank_d = vblank_q;
        colup0_d = colup0_q;
        colup1_d = colup1_q;
        colupf_d = colupf_q;
        colubk_d = colubk_q;
        ctrlpf_d = ctrlpf_q;
        pf0_d    = pf0_q;
        pf1_d    = pf1_q;
        pf2_d    = pf2_q;
        if (we) begin
            case (a)
                A_VSYNC:  vsync_d  = d[1];
                A_VBLANK: vblank_d = d[1];
                A_COLUP0: colup0_d = d[7:1];
                A_COLUP1: colup1_d = d[7:1];
                A_COLUPF: colupf_d = d[7:1];
                A_COLUBK: colubk_d = d[7:1];
                A_CTRLPF: ctrlpf_d = d[2:0];
                A_PF0:    pf0_d    = d[7:4];
                A_PF1:    pf1_d    = d;
                A_PF2:    pf2_d    = d;
                default:  ;
            endcase
        end
    end

    // Timing and register state.
    always_ff @(posedge osc or posedge reset) begin
        if (reset) begin
            div_q    <= '0;
            phi_q    <= 1'b0;
            hcount_q <= '0;
            rdy_q    <= 1'b1;
            vsync_q  <= 1'b0;
            vblank_q <= 1'b0;
            colup0_q <= '0;
            colup1_q <= '0;
            colupf_q <= '0;
            colubk_q <= '0;
            ctrlpf_q <= '0;
            pf0_q    <= '0;
            pf1_q    <= '0;
            pf2_q    <= '0;
        end else begin
            div_q    <= div_d;
            phi_q    <= phi_d;
            hcount_q <= hcount_d;
            rdy_q    <= rdy_d;
            vsync_q  <= vsync_d;
            vblank_q <= vblank_d;
            colup0_q <= colup0_d;
            colup1_q <= colup1_d;
            colupf_q <= colupf_d;
            colubk_q <= colubk_d;
            ctrlpf_q <= ctrlpf_d;
            pf0_q    <= pf0_d;
            pf1_q    <= pf1_d;
            pf2_q    <= pf2_d;
        end
    end

    tia_player #(
        .RES_ADDR (A_RESP0),
        .GRP_ADDR (A_GRP0),
        .REF_ADDR (A_REFP0),
        .HBLANK   (HBLANK_CLKS)
    ) u_p0 (
        .osc      (osc),
        .reset    (reset),
        .we_i     (we),
        .a_i      (a),
        .d_i      (d),
        .hcount_i (hcount_q),
        .pix_o    (p0_on)
    );

    tia_player #(
        .RES_ADDR (A_RESP1),
        .GRP_ADDR (A_GRP1),
        .REF_ADDR (A_REFP1),
        .HBLANK   (HBLANK_CLKS)
    ) u_p1 (
        .osc      (osc),
        .reset    (reset),
        .we_i     (we),
        .a_i      (a),
        .d_i      (d),
        .hcount_i (hcount_q),
        .pix_o    (p1_on)
    );

    // PF vector in scan order: PF0[4..7], PF1[7..0], PF2[0..7].
    assign pf_bits = {pf2_q, bitrev8(pf1_q), pf0_q};

    // Playfield index: left half direct, right half repeated or mirrored.
    always_comb begin
        x      = hcount_q - HBLANK_CLKS;
        left   = (x < HALF_CLKS);
        half_x = left ? x : x - HALF_CLKS;
        pf_idx = half_x >> 2;
        if (!left && ctrlpf_q[0]) pf_idx = 8'd19 - pf_idx;
        pf_on  = pf_lookup(pf_bits, pf_idx);
    end

    // Colour selection; score mode paints the playfield in player colours.
    always_comb begin
        pf_col = colupf_q;
        if (ctrlpf_q[1]) pf_col = left ? colup0_q : colup1_q;
        src = pick_src(ctrlpf_q[2], pf_on, p0_on, p1_on);
        case (src)
            SRC_PF:  col = pf_col;
            SRC_P0:  col = colup0_q;
            SRC_P1:  col = colup1_q;
            default: col = colubk_q;
        endcase
    end

    // Blank/sync and the blanked luma/chroma for the current hcount.
    always_comb begin
        blank = (hcount_q < HBLANK_CLKS) || vblank_q;
        blk_d = ~blank;
        syn_d = vsync_q || ((hcount_q >= HSYNC_START) && (hcount_q <= HSYNC_END));
        l_d   = blank ? 3'd0 : col[3:1];
        c_d   = blank ? 4'd0 : col[7:4];
    end

    // Video outputs trail hcount by one colour clock.
    always_ff @(posedge osc or posedge reset) begin
        if (reset) begin
            blk_q <= 1'b0;
            syn_q <= 1'b0;
            l_q   <= '0;
            c_q   <= '0;
        end else begin
            blk_q <= blk_d;
            syn_q <= syn_d;
            l_q   <= l_d;
            c_q   <= c_d;
        end
    end

    assign blk_bar   = blk_q;
    assign syn       = syn_q;
    assign l         = l_q;
    assign c         = c_q;
    assign rdy       = rdy_q;
    assign phi_theta = phi_q;

endmodule

// File: tb/tb_tia_no_audio.sv
// Bench for tia_no_audio: directed scenarios plus randomized register
// contents, all checked against a frame-rule reference model.
module tb_tia_no_audio;

    logic       osc = 1'b0;
    logic       reset = 1'b1;
    logic       phi2 = 1'b0;
    logic [7:0] d = 8'h00;
    logic [5:0] a = 6'h00;
    logic       blk_bar, syn, rdy, phi_theta;
    logic [2:0] l;
    logic [3:0] c;

    tia_no_audio dut (
        .osc       (osc),
        .reset     (reset),
        .d         (d),
        .a         (a),
        .phi2      (phi2),
        .blk_bar   (blk_bar),
        .l         (l),
        .c         (c),
        .syn       (syn),
        .rdy       (rdy),
        .phi_theta (phi_theta)
    );

    always #5 osc = ~osc;

    int errors = 0;
    int checks = 0;

    // Reference model state: register bytes, beam position, CPU divider.
    logic [7:0] rm [0:63];
    int         hc_m, div_m, prev_h, pos0, pos1;
    logic       rdy_m, phi_m, vld;
    logic [8:0] exp_px;

    function automatic logic pf_bit(int i);
        logic [7:0] v;
        if (i < 4) begin v = rm[13]; return v[4+i]; end
        if (i < 12) begin v = rm[14]; return v[11-i]; end
        v = rm[15];
        return v[i-12];
    endfunction

    function automatic logic pl_bit(int x, int pos, logic [7:0] g, logic r);
        int off;
        off = (x - pos + 160) % 160;
        if (off >= 8) return 1'b0;
        return r ? g[off] : g[7-off];
    endfunction

    // {blk_bar, l, c, syn} expected for beam position h.
    function automatic logic [8:0] pixel(int h);
        logic       blank, sync, pf, p0, p1;
        int         x, i;
        logic [7:0] col, pfc;
        sync  = rm[0][1] || (h >= 16 && h <= 31);
        blank = (h < 68) || rm[1][1];
        if (blank) return {1'b0, 7'd0, sync};
        x = h - 68;
        i = (x < 80) ? x / 4 : (x - 80) / 4;
        if (x >= 80 && rm[10][0]) i = 19 - i;
        pf  = pf_bit(i);
        p0  = pl_bit(x, pos0, rm[27], rm[11][3]);
        p1  = pl_bit(x, pos1, rm[28], rm[12][3]);
        pfc = rm[10][1] ? ((x < 80) ? rm[6] : rm[7]) : rm[8];
        if (rm[10][2] && pf) col = pfc;
        else if (p0)         col = rm[6];
        else if (p1)         col = rm[7];
        else if (pf)         col = pfc;
        else                 col = rm[9];
        return {1'b1, col[3:1], col[7:4], sync};
    endfunction

    function automatic logic [8:0] dut_px();
        return {blk_bar, l, c, syn};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) rm[i] = 8'h00;
        hc_m = 0; div_m = 0; pos0 = 0; pos1 = 0; prev_h = 0;
        rdy_m = 1'b1; phi_m = 1'b0; vld = 1'b0; exp_px = '0;
    endtask

    // One colour clock: advance the model alongside the DUT.
    task automatic tick();
        int         ph, pd;
        logic       w;
        logic [5:0] wa;
        logic [7:0] wd;
        ph = hc_m; pd = div_m;
        w = phi2 && (pd == 2); wa = a; wd = d;
        @(posedge osc); #1;
        exp_px = pixel(ph);
        phi_m  = (pd == 0);
        div_m  = (pd + 1) % 3;
        hc_m   = (ph == 227) ? 0 : ph + 1;
        if (w) begin
            rm[wa] = wd;
            if (wa == 6'h03) hc_m = 0;
            if (wa == 6'h10) pos0 = (ph >= 68) ? ph - 68 : 0;
            if (wa == 6'h11) pos1 = (ph >= 68) ? ph - 68 : 0;
        end
        if (w && wa == 6'h02) rdy_m = 1'b0;
        else if (hc_m == 0)   rdy_m = 1'b1;
        prev_h = ph;
        vld = 1'b1;
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_px(string tag);
        chk(tag, 16'(dut_px()), 16'(exp_px));
    endtask

    // CPU write: waits for the last clock of a CPU cycle, strobes one clock.
    task automatic wr(logic [5:0] addr, logic [7:0] data);
        int n;
        n = 0;
        while (div_m != 2 && n < 10) begin tick(); n++; end
        a = addr; d = data; phi2 = 1'b1;
        tick();
        phi2 = 1'b0;
    endtask

    // Advance until the outputs reflect hcount h.
    task automatic wait_out(int h);
        int n;
        n = 0;
        while (!(vld && prev_h == h) && n < 1000) begin tick(); n++; end
        if (!(vld && prev_h == h)) begin
            checks++; errors++;
            $error("FAIL wait_out: hcount %0d not reached", h);
        end
    endtask

    // Advance until the current hcount is h.
    task automatic wait_pre(int h);
        int n;
        n = 0;
        while (hc_m != h && n < 1000) begin tick(); n++; end
        if (hc_m != h) begin
            checks++; errors++;
            $error("FAIL wait_pre: hcount %0d not reached", h);
        end
    endtask

    task automatic chk_phi_run(string tag);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk(tag, 16'(phi_theta), 16'(k % 3 == 0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int regs [12] = '{6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 27, 28};

        model_reset();
        repeat (3) @(posedge osc);
        #1;
        chk("rst_px", 16'(dut_px()), 16'h0);
        chk("rst_rdy", 16'(rdy), 16'h1);
        chk("rst_phi", 16'(phi_theta), 16'h0);
        reset = 1'b0;
        chk_phi_run("phi_after_rst");

        // Background colour and hblank.
        wr(6'h09, 8'h9A);
        wait_out(100);
        chk_px("bk_h100");
        chk("bk_blk", 16'(blk_bar), 16'h1);
        chk("bk_c", 16'(c), 16'h9);
        chk("bk_l", 16'(l), 16'h5);
        wait_out(40);
        chk_px("hblank_h40");
        chk("hblank_blk", 16'(blk_bar), 16'h0);
        chk("hblank_lc", 16'({l, c}), 16'h0);

        // Reset asserted mid-line, between clock edges.
        wait_out(120);
        reset = 1'b1;
        #1;
        chk("mrst_px", 16'(dut_px()), 16'h0);
        chk("mrst_rdy", 16'(rdy), 16'h1);
        chk("mrst_phi", 16'(phi_theta), 16'h0);
        @(posedge osc);
        #1;
        reset = 1'b0;
        model_reset();
        chk_phi_run("phi_after_mrst");
        wr(6'h09, 8'h9A);

        // WSYNC mid-line, WSYNC on the wrap edge, and RSYNC release.
        wait_pre(50);
        wr(6'h02, 8'h00);
        chk("wsync_lo", 16'(rdy), 16'h0);
        wait_pre(227);
        chk("wsync_hold", 16'(rdy), 16'h0);
        tick();
        chk("wsync_rel", 16'(rdy), 16'h1);
        wait_pre(227);
        wr(6'h02, 8'h00);
        chk("wrap_lo", 16'(rdy), 16'h0);
        wait_pre(150);
        chk("wrap_hold", 16'(rdy), 16'h0);
        wait_pre(0);
        chk("wrap_rel", 16'(rdy), 16'h1);
        wait_pre(80);
        wr(6'h02, 8'h00);
        chk("rsync_pre", 16'(rdy), 16'h0);
        wr(6'h03, 8'h00);
        chk("rsync_rel", 16'(rdy), 16'h1);
        wait_out(67);
        chk("rsync_h67", 16'(blk_bar), 16'h0);
        wait_out(68);
        chk("rsync_h68", 16'(blk_bar), 16'h1);
        chk_px("rsync_px");

        // Playfield, repeated then mirrored.
        wr(6'h0D, 8'h10);
        wr(6'h08, 8'h0E);
        wr(6'h0A, 8'h00);
        for (int x = 0; x < 85; x++) begin
            if (x <= 4 || x >= 80) begin
                wait_out(68 + x);
                chk_px($sformatf("pf_rep_x%0d", x));
                if (x == 0) chk("pf_x0_lc", 16'({l, c}), 16'h70);
                if (x == 4) chk("pf_x4_lc", 16'({l, c}), 16'h59);
            end
        end
        wr(6'h0A, 8'h01);
        wait_out(68 + 80);
        chk_px("pf_refl_x80");
        chk("pf_refl_x80_lc", 16'({l, c}), 16'h59);
        for (int x = 156; x < 160; x++) begin
            wait_out(68 + x);
            chk_px($sformatf("pf_refl_x%0d", x));
        end
        chk("pf_refl_x159_lc", 16'({l, c}), 16'h70);

        // Player 0: position x=42 (a CPU-cycle-aligned slot), normal/reflected.
        wr(6'h0A, 8'h00);
        wait_pre(110);
        wr(6'h10, 8'h00);
        wr(6'h1B, 8'h80);
        wr(6'h06, 8'h44);
        for (int x = 38; x <= 52; x++) begin
            wait_out(68 + x);
            chk_px($sformatf("p0_x%0d", x));
            if (x == 42) chk("p0_x42_lc", 16'({l, c}), 16'h24);
            if (x == 43) chk("p0_x43_lc", 16'({l, c}), 16'h59);
        end
        wr(6'h0B, 8'h08);
        for (int x = 38; x <= 52; x++) begin
            wait_out(68 + x);
            chk_px($sformatf("p0ref_x%0d", x));
            if (x == 42) chk("p0ref_x42_lc", 16'({l, c}), 16'h59);
            if (x == 49) chk("p0ref_x49_lc", 16'({l, c}), 16'h24);
        end
        wr(6'h0B, 8'h00);
        wr(6'h0E, 8'h02);
        wr(6'h0A, 8'h04);
        wait_out(68 + 42);
        chk_px("pfpri_x42");
        chk("pfpri_x42_lc", 16'({l, c}), 16'h70);
        wr(6'h0A, 8'h00);
        wait_out(68 + 42);
        chk_px("p0pri_x42");
        chk("p0pri_x42_lc", 16'({l, c}), 16'h24);

        // Vertical sync, horizontal sync window, vertical blank.
        wr(6'h00, 8'h02);
        wait_out(0);   chk("vs_h0", 16'(syn), 16'h1);
        wait_out(100); chk("vs_h100", 16'(syn), 16'h1);
        wait_out(200); chk("vs_h200", 16'(syn), 16'h1);
        wr(6'h00, 8'h00);
        wait_out(15);  chk("hs_h15", 16'(syn), 16'h0);
        wait_out(16);  chk("hs_h16", 16'(syn), 16'h1);
        wait_out(31);  chk("hs_h31", 16'(syn), 16'h1);
        wait_out(32);  chk("hs_h32", 16'(syn), 16'h0);
        wr(6'h01, 8'h02);
        wait_out(100); chk("vb_h100", 16'(blk_bar), 16'h0);
        chk_px("vb_px100");
        wait_out(150); chk("vb_h150", 16'(blk_bar), 16'h0);
        wr(6'h01, 8'h00);

        // Randomized register contents and player positions, full-line scans.
        for (int r = 0; r < 8; r++) begin
            foreach (regs[i]) wr(6'(regs[i]), 8'($urandom));
            wr(6'h01, ($urandom_range(0, 3) == 0) ? 8'h02 : 8'h00);
            repeat ($urandom_range(0, 227)) tick();
            wr(6'h10, 8'h00);
            repeat ($urandom_range(0, 227)) tick();
            wr(6'h11, 8'h00);
            for (int k = 0; k < 228; k++) begin
                tick();
                chk($sformatf("rand%0d_h%0d", r, prev_h),
                    16'({dut_px(), rdy, phi_theta}), 16'({exp_px, rdy_m, phi_m}));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
